// File: rtl/jtag_scan_ctrl_if.sv
// Command/response bundle and TAP pins for the JTAG scan sequencer.
// master = sequence layer + target pins, slave = scan controller.
interface jtag_scan_ctrl_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;
  logic               tms;
  logic               tdi;
  logic               tdo;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    output rsp_ready, tdo,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  tms, tdi
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    input  rsp_ready, tdo,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output tms, tdi
  );
endinterface

// File: rtl/jtag_scan_ctrl.sv
// JTAG scan sequencer: walks the TAP from Run-Test/Idle for one
// IR/DR scan or TAP reset per command and returns the captured tdo.
module jtag_scan_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input logic             tck,
  input logic             trst,
  jtag_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [1:0] OP_DR  = 2'd0;
  localparam logic [1:0] OP_IR  = 2'd1;
  localparam logic [1:0] OP_RST = 2'd2;

  typedef enum logic [3:0] {
    IDLE, SEL_DR, SEL_IR, CAPTURE,
    SHIFT, EXIT1, UPDATE, TLR, RESP
  } state_t;

  state_t             state;
  logic [2:0]         tlr_cnt;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;
  logic [1:0]         op_q;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] rsp_data_q;
  logic               tms_q;
  logic               tdi_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic               bad_len;
  logic               bad_cmd;
  logic               last;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.tms       = tms_q;
  assign bus.tdi       = tdi_q;

  assign bad_len = (bus.cmd_len == '0) ||
                   (bus.cmd_len > LEN_W'(MAX_LEN));
  assign last    = (cnt == len_q - LEN_W'(1));

  always_comb begin
    bad_cmd = 1'b1;
    unique case (1'b1)
      (bus.cmd_op == OP_DR),
      (bus.cmd_op == OP_IR):  bad_cmd = bad_len;
      (bus.cmd_op == OP_RST): bad_cmd = 1'b0;
      default:                bad_cmd = 1'b1;
    endcase
  end

  // State mirrors the target's TAP state during the current cycle;
  // IDLE with cmd_ready low is the first (tms=1) cycle of a scan.
  always_ff @(posedge tck) begin
    if (trst) begin
      state       <= TLR;
      tlr_cnt     <= '0;
      cnt         <= '0;
      len_q       <= '0;
      op_q        <= OP_DR;
      data_q      <= '0;
      rsp_data_q  <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready_q) begin
            if (bus.cmd_valid) begin
              cmd_ready_q <= 1'b0;
              op_q        <= bus.cmd_op;
              len_q       <= bus.cmd_len;
              data_q      <= bus.cmd_data;
              rsp_data_q  <= '0;
              cnt         <= '0;
              if (bad_cmd) begin
                state       <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end else if (bus.cmd_op == OP_RST) begin
                state   <= TLR;
                tlr_cnt <= 3'd1;
                tms_q   <= 1'b1;
              end else begin
                tms_q <= 1'b1;
              end
            end
          end else begin
            state <= SEL_DR;
            tms_q <= (op_q == OP_IR);
          end
        end
        SEL_DR: begin
          state <= (op_q == OP_IR) ? SEL_IR : CAPTURE;
          tms_q <= 1'b0;
        end
        SEL_IR: begin
          state <= CAPTURE;
          tms_q <= 1'b0;
        end
        CAPTURE: begin
          state <= SHIFT;
          cnt   <= '0;
          tms_q <= (len_q == LEN_W'(1));
          tdi_q <= data_q[0];
        end
        SHIFT: begin
          rsp_data_q[cnt[IDX_W-1:0]] <= bus.tdo;
          data_q <= data_q >> 1;
          if (last) begin
            state <= EXIT1;
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
          end else begin
            cnt   <= cnt + LEN_W'(1);
            tms_q <= (cnt + LEN_W'(2) == len_q);
            tdi_q <= data_q[1];
          end
        end
        EXIT1: begin
          state <= UPDATE;
          tms_q <= 1'b0;
        end
        UPDATE: begin
          state       <= RESP;
          tms_q       <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
        end
        TLR: begin
          // Five tms=1 cycles reach Test-Logic-Reset from anywhere.
          if (tlr_cnt == 3'd6) begin
            tms_q <= 1'b0;
            if (op_q == OP_RST) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
            end else begin
              state       <= IDLE;
              cmd_ready_q <= 1'b1;
            end
          end else begin
            tlr_cnt <= tlr_cnt + 3'd1;
            tms_q   <= (tlr_cnt < 3'd5);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= TLR;
          tlr_cnt <= '0;
          tms_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Bench for jtag_scan_ctrl: a behavioural IEEE 1149.1 TAP target
// echoes a pattern on tdo and records tdi; scans are checked against it.
module tb_jtag_scan_ctrl;

  localparam int ML = 32;
  localparam int LW = 6;

  logic tck  = 1'b0;
  logic trst = 1'b1;

  jtag_scan_ctrl_if #(.MAX_LEN(ML), .LEN_W(LW)) bus ();

  jtag_scan_ctrl #(.MAX_LEN(ML), .LEN_W(LW)) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
  );

  always #5 tck = ~tck;

  typedef enum int {
    T_TLR, T_RTI, T_SDRS, T_CDR, T_SDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
    T_SIRS, T_CIR, T_SIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_t;

  typedef struct {
    logic [1:0]  op;
    int          len;
    logic [31:0] data;
    logic [31:0] echo;
    int          hold;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } vec_t;

  int tests = 0;
  int fails = 0;

  tap_t        tap    = T_SIR;
  int          sh_idx = 0;
  int          shifts = 0;
  logic        sh_ir  = 1'b0;
  logic [31:0] cap    = '0;
  logic [31:0] echo_pat = '0;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDRS : T_RTI;
      T_SDRS: return m ? T_SIRS : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SDR;
      T_SDR:  return m ? T_E1DR : T_SDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SDR;
      T_UDR:  return m ? T_SDRS : T_RTI;
      T_SIRS: return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SIR;
      T_SIR:  return m ? T_E1IR : T_SIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SIR;
      default: return m ? T_SDRS : T_RTI;
    endcase
  endfunction

  // Target TAP: samples tms/tdi on posedge, presents tdo on negedge.
  always @(posedge tck) begin
    if (tap == T_CDR || tap == T_CIR) begin
      sh_idx <= 0;
      cap    <= '0;
    end
    if (tap == T_SDR || tap == T_SIR) begin
      if (sh_idx < 32) cap[sh_idx] <= bus.tdi;
      sh_idx <= sh_idx + 1;
      shifts <= shifts + 1;
      sh_ir  <= (tap == T_SIR);
    end
    tap <= tap_next(tap, bus.tms);
  end

  always @(negedge tck) begin
    if ((tap == T_SDR || tap == T_SIR) && sh_idx < 32)
      bus.tdo = echo_pat[sh_idx];
    else
      bus.tdo = 1'b0;
  end

  function automatic logic [31:0] lmask(input int len);
    if (len >= 32) return '1;
    return (32'h1 << len) - 32'h1;
  endfunction

  function automatic logic [63:0] exp_tms(input logic [1:0] op,
                                          input int len);
    logic [63:0] v;
    int k;
    v = '0;
    k = 0;
    if (op == 2'd2) return 64'b011111;
    if (op == 2'd3 || len < 1 || len > 32) return '0;
    v[k] = 1'b1; k = k + 1;
    if (op == 2'd1) begin v[k] = 1'b1; k = k + 1; end
    v[k] = 1'b0; k = k + 1;
    v[k] = 1'b0; k = k + 1;
    for (int i = 0; i < len; i++) begin
      v[k] = (i == len - 1); k = k + 1;
    end
    v[k] = 1'b1; k = k + 1;
    v[k] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op,
                         input int len, input logic [31:0] data,
                         input logic [31:0] echo, input int hold,
                         input logic xerr, input logic [31:0] xdata,
                         input int xcyc);
    int w;
    int n;
    int sh0;
    logic [63:0] tl;
    echo_pat = echo;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LW'(len);
    bus.cmd_data  = data;
    w = 0;
    while (!bus.cmd_ready && w < 100) begin
      @(negedge tck);
      w++;
    end
    chk({tag, " accept"}, 64'(bus.cmd_ready), 64'd1);
    sh0 = shifts;
    @(negedge tck);
    bus.cmd_valid = 1'b0;
    n  = 0;
    tl = '0;
    while (!bus.rsp_valid && n < 100) begin
      if (n < 64) tl[n] = bus.tms;
      @(negedge tck);
      n++;
    end
    chk({tag, " cycles"}, 64'(n), 64'(xcyc));
    chk({tag, " tms seq"}, tl, exp_tms(op, len));
    chk({tag, " rsp_err"}, 64'(bus.rsp_err), 64'(xerr));
    chk({tag, " rsp_data"}, 64'(bus.rsp_data), 64'(xdata));
    chk({tag, " tap idle"}, 64'(tap == T_RTI), 64'd1);
    if (xerr || op == 2'd2) begin
      chk({tag, " no shift"}, 64'(shifts - sh0), 64'd0);
    end else begin
      chk({tag, " tdi bits"}, 64'(cap), 64'(data & lmask(len)));
      chk({tag, " shift n"}, 64'(shifts - sh0), 64'(len));
      chk({tag, " ir/dr"}, 64'(sh_ir), 64'(op == 2'd1));
    end
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd2;
      @(negedge tck);
      chk({tag, " hold vld"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, " hold dat"}, 64'(bus.rsp_data), 64'(xdata));
      chk({tag, " hold err"}, 64'(bus.rsp_err), 64'(xerr));
      chk({tag, " hold rdy"}, 64'(bus.cmd_ready), 64'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge tck);
    bus.rsp_ready = 1'b0;
    chk({tag, " rsp drop"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, " turnaround"}, 64'(bus.cmd_ready), 64'd1);
    chk({tag, " quiet"}, 64'({bus.tms, bus.tdi, tap == T_RTI}), 64'b001);
  endtask

  task automatic tlr_replay(input string tag);
    logic [6:0] tl;
    logic [6:0] rl;
    for (int k = 0; k < 7; k++) begin
      @(negedge tck);
      tl[k] = bus.tms;
      rl[k] = bus.cmd_ready;
      if (bus.rsp_valid) chk({tag, " no rsp"}, 64'd1, 64'd0);
    end
    chk({tag, " tms"}, 64'(tl), 64'b0011111);
    chk({tag, " ready"}, 64'(rl), 64'b1000000);
    chk({tag, " tap"}, 64'(tap == T_RTI), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[11];

  initial begin
    int w;
    int r;
    int len;
    logic [1:0] op;
    logic [31:0] d;
    logic [31:0] e;
    logic err;

    vt[0]  = '{2'd0, 8,  32'hA5,       32'h3C,       0, 1'b0, 32'h3C,       13};
    vt[1]  = '{2'd1, 1,  32'h1,        32'hFFFFFFFF, 0, 1'b0, 32'h1,        7};
    vt[2]  = '{2'd0, 0,  32'hFF,       32'hFF,       0, 1'b1, 32'h0,        0};
    vt[3]  = '{2'd3, 8,  32'hFF,       32'hFF,       0, 1'b1, 32'h0,        0};
    vt[4]  = '{2'd0, 33, 32'hFF,       32'hFF,       0, 1'b1, 32'h0,        0};
    vt[5]  = '{2'd1, 0,  32'h1,        32'h1,        1, 1'b1, 32'h0,        0};
    vt[6]  = '{2'd2, 0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b0, 32'h0,        6};
    vt[7]  = '{2'd0, 32, 32'hDEADBEEF, 32'h12345678, 5, 1'b0, 32'h12345678, 37};
    vt[8]  = '{2'd1, 5,  32'h1F,       32'hFFFFFFFF, 2, 1'b0, 32'h1F,       11};
    vt[9]  = '{2'd0, 2,  32'h3,        32'hFFFFFFFE, 0, 1'b0, 32'h2,        7};
    vt[10] = '{2'd1, 32, 32'h0,        32'h80000001, 0, 1'b0, 32'h80000001, 38};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    trst = 1'b1;
    repeat (3) @(negedge tck);
    chk("reset outs",
        64'({bus.tms, bus.tdi, bus.cmd_ready, bus.rsp_valid, bus.rsp_err}),
        64'b10000);
    chk("reset data", 64'(bus.rsp_data), 64'd0);
    trst = 1'b0;
    tlr_replay("por");

    foreach (vt[i])
      run_cmd($sformatf("vec%0d", i), vt[i].op, vt[i].len, vt[i].data,
              vt[i].echo, vt[i].hold, vt[i].err, vt[i].rdata, vt[i].cyc);

    echo_pat = 32'h5A5AF00F;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_len   = LW'(32);
    bus.cmd_data  = 32'h12345678;
    @(negedge tck);
    bus.cmd_valid = 1'b0;
    w = 0;
    while (!(tap == T_SDR && sh_idx == 10) && w < 100) begin
      @(negedge tck);
      w++;
    end
    chk("abort reach bit10", 64'(sh_idx), 64'd10);
    trst = 1'b1;
    @(negedge tck);
    chk("abort reset",
        64'({bus.tms, bus.tdi, bus.cmd_ready, bus.rsp_valid}), 64'b1000);
    trst = 1'b0;
    tlr_replay("abort");
    run_cmd("after abort", 2'd0, 32, 32'hFFFF0000, 32'h5A5AF00F, 1,
            1'b0, 32'h5A5AF00F, 37);

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      len = ($urandom_range(0, 7) == 0) ? 33 * $urandom_range(0, 1)
                                        : $urandom_range(1, 32);
      d = $urandom;
      e = $urandom;
      err = (op == 2'd3) || (op != 2'd2 && (len < 1 || len > 32));
      run_cmd($sformatf("rnd%0d", i), op, len, d, e,
              $urandom_range(0, 3), err,
              (err || op == 2'd2) ? 32'h0 : (e & lmask(len)),
              err ? 0 : (op == 2'd2) ? 6 : len + 5 + int'(op == 2'd1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
